race_sequencer: RTL

- Race-flow controller between the main menu FSM and the gameplay datapath (car control, lap timer, checkpoints, lap-time overlays).
- Once the track screen is shown, runs a frame-based 3-2-1 start countdown and a "GO" phase.
- Then gates car control and lap-timer run, counts completed laps from checkpoint logic, and declares the race finished after a set number of laps.
- Outputs drive the car enable, lap-timer start and countdown/lap overlays.

---
 rtl/race_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/race_sequencer.sv
// Race-flow controller: 3-2-1 countdown, GO phase, lap counting, finish.
// Sits between the menu FSM and the gameplay datapath; all outputs registered.
module race_sequencer #(
  parameter int FRAMES_PER_STEP = 60,
  parameter int GO_FRAMES       = 60,
  parameter int LAPS            = 3
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       track_visible,
  input  logic       frame_ended,
  input  logic       lap_finished,
  output logic       car_enable,
  output logic       lap_timer_run,
  output logic       race_start,
  output logic       countdown_active,
  output logic [1:0] countdown_digit,
  output logic       go_visible,
  output logic [3:0] lap_count,
  output logic       race_finished,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_GO     = 3'd2,
    S_RACE   = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] GO_LAST   = 8'(GO_FRAMES - 1);
  localparam logic [3:0] LAP_GOAL  = 4'(LAPS);

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] digit_q, digit_d;
  logic [3:0] lap_q, lap_d;
  logic       car_q, car_d;
  logic       timer_q, timer_d;
  logic       start_q, start_d;
  logic       cd_act_q, cd_act_d;
  logic       go_q, go_d;
  logic       fin_q, fin_d;
  logic [3:0] lap_inc;

  assign lap_inc = lap_q + 4'd1;

  // State and output registers; reset and abort share the same cleared values
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= 8'd0;
      digit_q     <= 2'd0;
      lap_q       <= 4'd0;
      car_q       <= 1'b0;
      timer_q     <= 1'b0;
      start_q     <= 1'b0;
      cd_act_q    <= 1'b0;
      go_q        <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      digit_q     <= digit_d;
      lap_q       <= lap_d;
      car_q       <= car_d;
      timer_q     <= timer_d;
      start_q     <= start_d;
      cd_act_q    <= cd_act_d;
      go_q        <= go_d;
      fin_q       <= fin_d;
    end
  end

  // Next-state logic; abort (track hidden) overrides every other event
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    digit_d     = digit_q;
    lap_d       = lap_q;
    car_d       = car_q;
    timer_d     = timer_q;
    start_d     = 1'b0;
    cd_act_d    = cd_act_q;
    go_d        = go_q;
    fin_d       = fin_q;
    if (state_q != S_IDLE && !track_visible) begin
      state_d     = S_IDLE;
      frame_cnt_d = 8'd0;
      digit_d     = 2'd0;
      lap_d       = 4'd0;
      car_d       = 1'b0;
      timer_d     = 1'b0;
      cd_act_d    = 1'b0;
      go_d        = 1'b0;
      fin_d       = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (track_visible) begin
            state_d     = S_COUNT;
            frame_cnt_d = 8'd0;
            digit_d     = 2'd3;
            lap_d       = 4'd0;
            cd_act_d    = 1'b1;
          end
        end
        S_COUNT: begin
          if (frame_ended) begin
            if (frame_cnt_q == STEP_LAST) begin
              frame_cnt_d = 8'd0;
              if (digit_q == 2'd1) begin
                state_d  = S_GO;
                start_d  = 1'b1;
                car_d    = 1'b1;
                timer_d  = 1'b1;
                go_d     = 1'b1;
                cd_act_d = 1'b0;
                digit_d  = 2'd0;
              end else begin
                digit_d = digit_q - 2'd1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        S_GO: begin
          if (frame_ended) begin
            if (frame_cnt_q == GO_LAST) begin
              frame_cnt_d = 8'd0;
              state_d     = S_RACE;
              go_d        = 1'b0;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
          // A final lap during GO wins over the GO->RACE move
          if (lap_finished) begin
            lap_d = lap_inc;
            if (lap_inc == LAP_GOAL) begin
              state_d     = S_FINISH;
              frame_cnt_d = 8'd0;
              car_d       = 1'b0;
              timer_d     = 1'b0;
              go_d        = 1'b0;
              fin_d       = 1'b1;
            end
          end
        end
        S_RACE: begin
          if (lap_finished) begin
            lap_d = lap_inc;
            if (lap_inc == LAP_GOAL) begin
              state_d = S_FINISH;
              car_d   = 1'b0;
              timer_d = 1'b0;
              fin_d   = 1'b1;
            end
          end
        end
        S_FINISH: begin
          state_d = S_FINISH;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign state            = state_q;
  assign countdown_digit  = digit_q;
  assign lap_count        = lap_q;
  assign car_enable       = car_q;
  assign lap_timer_run    = timer_q;
  assign race_start       = start_q;
  assign countdown_active = cd_act_q;
  assign go_visible       = go_q;
  assign race_finished    = fin_q;

endmodule
